i2c_bus_arbiter: RTL and testbench

- Shares one I2C master engine between `NUM_REQ` requesters (sensor pollers, config loader, debug port).
- Arbitrates round-robin, registers the winner's transaction fields and issues a single start to the master.
- Waits for completion or a watchdog timeout, then returns read data and status to the winner.
- Sits between the requester logic and the I2C master; it never touches `i2c_sda`/`i2c_scl` itself.

---
 rtl/i2c_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin arbiter sharing one I2C master engine between requesters
module i2c_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]          req_rw,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [DATA_W-1:0]           rdata,
    output logic                        nack,
    output logic                        timeout,
    output logic                        m_start,
    output logic [ADDR_W-1:0]           m_addr,
    output logic                        m_rw,
    output logic [DATA_W-1:0]           m_wdata,
    output logic                        m_abort,
    input  logic                        m_done,
    input  logic                        m_nack,
    input  logic [DATA_W-1:0]           m_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT     = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [IDX_W-1:0]     ptr_q,     ptr_d;
    logic [IDX_W-1:0]     idx_q,     idx_d;
    logic [NUM_REQ-1:0]   gnt_q,     gnt_d;
    logic [ADDR_W-1:0]    m_addr_q,  m_addr_d;
    logic                 m_rw_q,    m_rw_d;
    logic [DATA_W-1:0]    m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0]    rdata_q,   rdata_d;
    logic                 nack_q,    nack_d;
    logic                 timeout_q, timeout_d;
    logic                 m_abort_q, m_abort_d;
    logic [WD_W-1:0]      wd_q,      wd_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;

    // First requester at or above ptr_q, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            gnt_q     <= '0;
            m_addr_q  <= '0;
            m_rw_q    <= 1'b0;
            m_wdata_q <= '0;
            rdata_q   <= '0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
            m_abort_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            m_addr_q  <= m_addr_d;
            m_rw_q    <= m_rw_d;
            m_wdata_q <= m_wdata_d;
            rdata_q   <= rdata_d;
            nack_q    <= nack_d;
            timeout_q <= timeout_d;
            m_abort_q <= m_abort_d;
            wd_q      <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        m_addr_d  = m_addr_q;
        m_rw_d    = m_rw_q;
        m_wdata_d = m_wdata_q;
        rdata_d   = rdata_q;
        nack_d    = nack_q;
        timeout_d = timeout_q;
        m_abort_d = 1'b0;
        wd_d      = wd_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d   = S_ISSUE;
                    idx_d     = win_idx;
                    gnt_d     = NUM_REQ'(1) << win_idx;
                    m_addr_d  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    m_rw_d    = req_rw[win_idx];
                    m_wdata_d = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the expiry cycle takes priority over the abort.
                if (m_done) begin
                    state_d   = S_COMPLETE;
                    rdata_d   = m_rdata;
                    nack_d    = m_nack;
                    timeout_d = 1'b0;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d   = S_COMPLETE;
                    m_abort_d = 1'b1;
                    nack_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_COMPLETE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_start = (state_q == S_ISSUE);
        done    = (state_q == S_COMPLETE) ? gnt_q : '0;
        gnt     = gnt_q;
        m_addr  = m_addr_q;
        m_rw    = m_rw_q;
        m_wdata = m_wdata_q;
        m_abort = m_abort_q;
        rdata   = rdata_q;
        nack    = nack_q;
        timeout = timeout_q;
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - bench for i2c_bus_arbiter: directed scenarios plus random traffic against a transaction model
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt, done;
    logic [DATA_W-1:0]         rdata, m_rdata, m_wdata;
    logic                      nack, timeout, m_start, m_rw, m_abort, m_done, m_nack;
    logic [ADDR_W-1:0]         m_addr;

    i2c_bus_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .nack(nack),
        .timeout(timeout), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
        .m_wdata(m_wdata), .m_abort(m_abort), .m_done(m_done), .m_nack(m_nack),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // master responder configuration (0 latency = never answers)
    int          resp_lat   = 0;
    logic        resp_nack  = 1'b0;
    logic [7:0]  resp_rdata = 8'h00;
    bit          rnd_mode   = 1'b0;
    int          stray_req  = 0;
    logic        stray_nack = 1'b0;
    logic [7:0]  stray_rdata = 8'h00;

    // event logs written only by the compare process
    int          start_cyc_q[$];
    logic [3:0]  start_gnt_q[$];
    logic [6:0]  start_addr_q[$];
    logic        start_rw_q[$];
    logic [7:0]  start_wdata_q[$];
    int          done_cyc_q[$];
    logic [3:0]  done_val_q[$];
    int          abort_cyc_q[$];

    // transaction-level reference: owner index, edges since grant, finishing flag
    int          mo = -1, mptr = 0, mage = 0;
    bit          mfin = 1'b0;
    logic [6:0]  e_addr = '0;
    logic        e_rw = 1'b0, e_abort = 1'b0, e_nack = 1'b0, e_to = 1'b0;
    logic [7:0]  e_wdata = '0, e_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                mo = -1; mptr = 0; mage = 0; mfin = 1'b0;
                e_addr = '0; e_rw = 1'b0; e_wdata = '0; e_abort = 1'b0;
                e_rdata = '0; e_nack = 1'b0; e_to = 1'b0;
            end else begin
                e_abort = 1'b0;
                if (mo >= 0 && mfin) begin
                    mptr = (mo + 1) % NUM_REQ;
                    mo   = -1;
                    mfin = 1'b0;
                end else if (mo < 0) begin
                    for (int k = 0; k < NUM_REQ; k++)
                        if (mo < 0 && req[(mptr + k) % NUM_REQ]) mo = (mptr + k) % NUM_REQ;
                    if (mo >= 0) begin
                        mage    = 0;
                        e_addr  = req_addr[mo*ADDR_W +: ADDR_W];
                        e_rw    = req_rw[mo];
                        e_wdata = req_wdata[mo*DATA_W +: DATA_W];
                    end
                end else if (mage == 0) begin
                    mage = 1;
                end else if (m_done) begin
                    mfin = 1'b1; e_rdata = m_rdata; e_nack = m_nack; e_to = 1'b0;
                end else if (mage == TIMEOUT) begin
                    mfin = 1'b1; e_abort = 1'b1; e_nack = 1'b1; e_to = 1'b1;
                end else begin
                    mage++;
                end
            end
        end
    end

    initial begin
        logic [3:0] e_gnt, e_done;
        logic       e_start;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_gnt   = (mo >= 0) ? 4'(1 << mo) : 4'b0;
                e_done  = (mo >= 0 && mfin) ? e_gnt : 4'b0;
                e_start = (mo >= 0 && !mfin && mage == 0);
                n_total++;
                if (gnt === e_gnt && done === e_done && m_start === e_start && m_abort === e_abort &&
                    m_addr === e_addr && m_rw === e_rw && m_wdata === e_wdata &&
                    rdata === e_rdata && nack === e_nack && timeout === e_to)
                    n_pass++;
                else
                    $display("FAIL cycle_%0d outputs: gnt %b/%b done %b/%b start %b/%b abort %b/%b addr %h/%h rw %b/%b wdata %h/%h rdata %h/%h nack %b/%b timeout %b/%b (got/expected)",
                             cyc, gnt, e_gnt, done, e_done, m_start, e_start, m_abort, e_abort,
                             m_addr, e_addr, m_rw, e_rw, m_wdata, e_wdata, rdata, e_rdata,
                             nack, e_nack, timeout, e_to);
                if (m_start === 1'b1) begin
                    start_cyc_q.push_back(cyc);   start_gnt_q.push_back(gnt);
                    start_addr_q.push_back(m_addr); start_rw_q.push_back(m_rw);
                    start_wdata_q.push_back(m_wdata);
                end
                if (|done) begin
                    done_cyc_q.push_back(cyc); done_val_q.push_back(done);
                end
                if (m_abort === 1'b1) abort_cyc_q.push_back(cyc);
            end
        end
    end

    // I2C master stand-in
    initial begin
        int cnt, lat, stray_ack;
        cnt = -1; stray_ack = 0;
        m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
        forever begin
            @(posedge clk); #1;
            m_done = 1'b0;
            if (rnd_mode) begin m_nack = 1'($urandom); m_rdata = 8'($urandom); end
            if (gnt == 4'b0) cnt = -1;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    m_done = 1'b1;
                    if (!rnd_mode) begin m_nack = resp_nack; m_rdata = resp_rdata; end
                    cnt = -1;
                end
            end else if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                m_done = 1'b1; m_nack = stray_nack; m_rdata = stray_rdata;
            end else if (rnd_mode && $urandom_range(0, 15) == 0) begin
                m_done = 1'b1;
            end
            if (m_start) begin
                lat = rnd_mode ? int'($urandom_range(0, 20)) : resp_lat;
                cnt = (lat > 0) ? lat : -1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        req_addr[i*ADDR_W +: ADDR_W]  = a;
        req_rw[i]                     = rw;
        req_wdata[i*DATA_W +: DATA_W] = wd;
        req[i]                        = 1'b1;
    endtask

    task automatic wait_dones(input int n, input int budget, input string nm);
        int b;
        b = budget;
        while (done_cyc_q.size() < n && b > 0) begin step(); b--; end
        chk(nm, 32'(done_cyc_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        int bs, bd, ba;
        logic [3:0] rr_order [5];
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
        step(); chk_en = 1'b1; step(); reset = 1'b0;

        chk("rst_gnt",     32'(gnt), 0);
        chk("rst_done",    32'(done), 0);
        chk("rst_m_start", 32'(m_start), 0);
        chk("rst_rdata",   32'(rdata), 0);
        chk("rst_nack",    32'({nack, timeout}), 0);
        chk("rst_m_addr",  32'(m_addr), 0);

        // single write from requester 2
        bs = start_cyc_q.size(); bd = done_cyc_q.size();
        resp_lat = 12; resp_nack = 1'b0; resp_rdata = 8'hC3;
        set_req(2, 7'h50, 1'b0, 8'hA5);
        wait_dones(bd + 1, 80, "t1_done_seen");
        req[2] = 1'b0;
        chk("t1_starts",  32'(start_cyc_q.size() - bs), 1);
        chk("t1_gnt",     32'(start_gnt_q[bs]), 32'h4);
        chk("t1_m_addr",  32'(start_addr_q[bs]), 32'h50);
        chk("t1_m_wdata", 32'(start_wdata_q[bs]), 32'hA5);
        chk("t1_m_rw",    32'(start_rw_q[bs]), 0);
        chk("t1_done",    32'(done_val_q[bd]), 32'h4);
        chk("t1_latency", 32'(done_cyc_q[bd] - start_cyc_q[bs]), 13);
        chk("t1_nack",    32'(nack), 0);

        // round-robin with all requesters held
        do_reset();
        bs = start_cyc_q.size(); bd = done_cyc_q.size();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 7'(7'h10 + i), 1'(i), 8'(8'h20 + i));
        resp_lat = 5;
        wait_dones(bd + 5, 200, "t2_done_seen");
        req = '0;
        repeat (4) step();
        chk("t2_starts", 32'(start_cyc_q.size() - bs), 5);
        chk("t2_dones",  32'(done_cyc_q.size() - bd), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_gnt_%0d", k),  32'(start_gnt_q[bs + k]), 32'(rr_order[k]));
            chk($sformatf("t2_done_%0d", k), 32'(done_val_q[bd + k]), 32'(rr_order[k]));
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2_turnaround_%0d", k), 32'(start_cyc_q[bs + k + 1] - done_cyc_q[bd + k]), 2);

        // read with NACK
        bs = start_cyc_q.size(); bd = done_cyc_q.size();
        resp_lat = 3; resp_nack = 1'b1; resp_rdata = 8'h7E;
        set_req(1, 7'h3C, 1'b1, 8'h00);
        wait_dones(bd + 1, 60, "t3_done_seen");
        req[1] = 1'b0;
        chk("t3_m_addr",  32'(start_addr_q[bs]), 32'h3C);
        chk("t3_m_rw",    32'(start_rw_q[bs]), 1);
        chk("t3_done",    32'(done_val_q[bd]), 32'h2);
        chk("t3_rdata",   32'(rdata), 32'h7E);
        chk("t3_nack",    32'(nack), 1);
        chk("t3_timeout", 32'(timeout), 0);

        // watchdog timeout
        bs = start_cyc_q.size(); bd = done_cyc_q.size(); ba = abort_cyc_q.size();
        resp_lat = 0;
        set_req(0, 7'h22, 1'b0, 8'h99);
        wait_dones(bd + 1, 80, "t4_done_seen");
        req[0] = 1'b0;
        chk("t4_aborts",      32'(abort_cyc_q.size() - ba), 1);
        chk("t4_abort_delay", 32'(abort_cyc_q[ba] - (start_cyc_q[bs] + 1)), 16);
        chk("t4_done_cycle",  32'(done_cyc_q[bd] - abort_cyc_q[ba]), 0);
        chk("t4_done",        32'(done_val_q[bd]), 32'h1);
        chk("t4_status",      32'({nack, timeout}), 32'h3);
        chk("t4_rdata_held",  32'(rdata), 32'h7E);

        // m_done on the expiry cycle beats the watchdog
        bs = start_cyc_q.size(); bd = done_cyc_q.size(); ba = abort_cyc_q.size();
        resp_lat = 16; resp_nack = 1'b0; resp_rdata = 8'h5A;
        set_req(2, 7'h41, 1'b1, 8'h00);
        wait_dones(bd + 1, 80, "t5_done_seen");
        req[2] = 1'b0;
        chk("t5_aborts",  32'(abort_cyc_q.size() - ba), 0);
        chk("t5_latency", 32'(done_cyc_q[bd] - start_cyc_q[bs]), 17);
        chk("t5_status",  32'({nack, timeout}), 0);
        chk("t5_rdata",   32'(rdata), 32'h5A);

        // stray master completion while idle
        repeat (2) step();
        bd = done_cyc_q.size();
        stray_nack = 1'b1; stray_rdata = 8'h11; stray_req++;
        repeat (4) step();
        chk("t5_stray_dones",  32'(done_cyc_q.size() - bd), 0);
        chk("t5_stray_rdata",  32'(rdata), 32'h5A);
        chk("t5_stray_status", 32'({nack, timeout}), 0);

        // reset during WAIT, then a fresh request
        resp_lat = 0;
        set_req(1, 7'h0F, 1'b1, 8'h00);
        repeat (8) step();
        reset = 1'b1; req = '0;
        step();
        reset = 1'b0;
        chk("t6_gnt",     32'(gnt), 0);
        chk("t6_strobes", 32'({done, m_start, m_abort}), 0);
        chk("t6_status",  32'({rdata, nack, timeout}), 0);
        bd = done_cyc_q.size();
        resp_lat = 4; resp_nack = 1'b0; resp_rdata = 8'h3D;
        set_req(3, 7'h77, 1'b0, 8'h12);
        wait_dones(bd + 1, 60, "t6_done_seen");
        req[3] = 1'b0;
        chk("t6_gnt_after", 32'(start_gnt_q[start_gnt_q.size() - 1]), 32'h8);
        chk("t6_done",      32'(done_val_q[bd]), 32'h8);
        chk("t6_rdata",     32'(rdata), 32'h3D);

        // random traffic
        rnd_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            req       = 4'($urandom & $urandom);
            req_addr  = 28'($urandom);
            req_rw    = 4'($urandom);
            req_wdata = 32'($urandom);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; req = '0; rnd_mode = 1'b0;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
